// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
    logic p;
    p = ^data;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter: tick is high during the last cycle of each bit time.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_q;

  // Saturates at the terminal count until cleared by the owner.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: loads a byte on ld and shifts it out LSB-first as
// start, 8 data bits, optional parity and one stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned PARITY       = PAR_NONE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld,
  input  logic [7:0] d,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam bit HAS_PARITY = (PARITY != PAR_NONE);

  tx_state_t  state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] idx_q,   idx_d;
  logic       par_q,   par_d;
  logic       tx_q,    tx_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;
  logic       tick;
  logic       timer_clr;

  // Held clear while idle and restarted on every bit boundary.
  assign timer_clr = (state_q == ST_IDLE) || tick;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (timer_clr),
    .tick (tick)
  );

  // tx_d is the line level for the state being entered, so tx stays registered.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (ld) begin
          shreg_d = d;
          par_d   = parity_bit(d, PARITY);
          idx_d   = 3'd0;
          state_d = ST_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
          tx_d    = shreg_q[0];
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
            if (HAS_PARITY) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            shreg_d = {1'b0, shreg_q[7:1]};
            idx_d   = idx_q + 3'd1;
            tx_d    = shreg_q[1];
          end
        end
      end

      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end

      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= 8'h00;
      idx_q   <= 3'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
